sm3_stream: RTL

Streaming SM3 hash engine: accepts a message of arbitrary byte length as 32-bit big-endian words over a valid/ready handshake, performs SM3 padding internally, and iterates the compression function one round per cycle across as many 512-bit blocks as the message needs. It succeeds the fixed-length `sm3` core, whose message length is a build-time parameter. It sits between a byte/word source (DMA or host register FIFO) and any consumer of the 256-bit digest.

---
 rtl/sm3_stream.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/sm3_stream.sv
// Streaming SM3 hash engine: word-wide message intake, internal padding and
// one compression round per clock over as many 512-bit blocks as needed.
module sm3_stream #(
  parameter int unsigned  LEN_W = 64,
  parameter logic [255:0] IV    = 256'h7380166f_4914b2b9_172442d7_da8a0600_a96f30bc_163138aa_e38dee4d_b0fb0e4e
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  input  logic         in_last,
  input  logic [2:0]   in_keep,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [255:0] digest
);

  // state | meaning
  // LOAD  | accepting message words into the block buffer
  // PAD   | completing the buffer with 0x80, zeros and/or the bit length
  // COMP  | 64 compression rounds, one per cycle
  // UPD   | fold working registers into the chaining value, pick next block
  // OUT   | digest presented until the consumer accepts it
  typedef enum logic [2:0] {LOAD, PAD, COMP, UPD, OUT} state_t;

  localparam logic [31:0] T_LO = 32'h79cc4519;
  localparam logic [31:0] T_HI = 32'h7a879d8a;

  function automatic logic [31:0] rol(input logic [31:0] x, input logic [4:0] n);
    logic [63:0] t;
    t = {x, x} << n;
    return t[63:32];
  endfunction

  function automatic logic [31:0] p0(input logic [31:0] x);
    return x ^ rol(x, 5'd9) ^ rol(x, 5'd17);
  endfunction

  function automatic logic [31:0] p1(input logic [31:0] x);
    return x ^ rol(x, 5'd15) ^ rol(x, 5'd23);
  endfunction

  function automatic logic [31:0] ffj(input logic [31:0] x, input logic [31:0] y,
                                      input logic [31:0] z, input logic hi);
    return hi ? ((x & y) | (x & z) | (y & z)) : (x ^ y ^ z);
  endfunction

  function automatic logic [31:0] ggj(input logic [31:0] x, input logic [31:0] y,
                                      input logic [31:0] z, input logic hi);
    return hi ? ((x & y) | (~x & z)) : (x ^ y ^ z);
  endfunction

  state_t           state;
  logic [31:0]      blk [16];
  logic [31:0]      pad_blk [16];
  logic [3:0]       ptr;
  logic [LEN_W-1:0] bit_cnt;
  logic [LEN_W-1:0] bit_inc;
  logic [63:0]      len64;
  logic [6:0]       pad_pos;
  logic             pad_pend;
  logic             len_pend;
  logic             msg_done;
  logic [5:0]       rnd;
  logic [255:0]     v;
  logic [31:0]      ra, rb, rc, rd, re, rf, rg, rh;

  logic [2:0]       keep_eff;
  logic             accept;
  logic             buf_full;
  logic             hi_rnd;
  logic [31:0]      tj, a12, ss1, ss2, tt1, tt2, w_new;

  assign keep_eff = (in_keep > 3'd4) ? 3'd4 : in_keep;
  assign accept   = in_valid & in_ready;
  assign buf_full = (ptr == 4'd15);
  assign bit_inc  = LEN_W'({keep_eff, 3'b000});

  always_comb begin
    len64 = '0;
    len64[LEN_W-1:0] = bit_cnt;
  end

  // Bytes before pad_pos are message data, the byte at pad_pos is the 0x80
  // marker; a pending length block ignores both and carries only the length.
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      pad_blk[i] = '0;
      for (int b = 0; b < 4; b++) begin
        if (!len_pend && (7'(4 * i + b) < pad_pos))
          pad_blk[i][8*(3-b) +: 8] = blk[i][8*(3-b) +: 8];
        else if (!len_pend && (7'(4 * i + b) == pad_pos))
          pad_blk[i][8*(3-b) +: 8] = 8'h80;
      end
    end
    if (len_pend || (pad_pos < 7'd56)) begin
      pad_blk[14] = len64[63:32];
      pad_blk[15] = len64[31:0];
    end
  end

  // blk[0] holds W_j and blk[4] holds W_{j+4} while the window slides.
  always_comb begin
    hi_rnd = (rnd >= 6'd16);
    tj     = rol(hi_rnd ? T_HI : T_LO, rnd[4:0]);
    a12    = rol(ra, 5'd12);
    ss1    = rol(a12 + re + tj, 5'd7);
    ss2    = ss1 ^ a12;
    tt1    = ffj(ra, rb, rc, hi_rnd) + rd + ss2 + (blk[0] ^ blk[4]);
    tt2    = ggj(re, rf, rg, hi_rnd) + rh + ss1 + blk[0];
    w_new  = p1(blk[0] ^ blk[7] ^ rol(blk[13], 5'd15)) ^ rol(blk[3], 5'd7) ^ blk[10];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= LOAD;
      v         <= IV;
      bit_cnt   <= '0;
      ptr       <= '0;
      rnd       <= '0;
      pad_pos   <= '0;
      pad_pend  <= 1'b0;
      len_pend  <= 1'b0;
      msg_done  <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      digest    <= '0;
    end else begin
      case (state)
        LOAD: begin
          in_ready <= 1'b1;
          if (accept) begin
            bit_cnt <= bit_cnt + bit_inc;
            if (in_last) begin
              msg_done <= 1'b1;
              in_ready <= 1'b0;
              if (buf_full && (keep_eff == 3'd4)) begin
                pad_pend <= 1'b1;
                rnd      <= '0;
                state    <= COMP;
              end else begin
                pad_pos <= {1'b0, ptr, 2'b00} + {4'b0000, keep_eff};
                state   <= PAD;
              end
            end else if (buf_full) begin
              in_ready <= 1'b0;
              rnd      <= '0;
              state    <= COMP;
            end else begin
              ptr <= ptr + 4'd1;
            end
          end
        end
        PAD: begin
          if (len_pend)
            len_pend <= 1'b0;
          else if (pad_pos >= 7'd56)
            len_pend <= 1'b1;
          rnd   <= '0;
          state <= COMP;
        end
        COMP: begin
          rnd <= rnd + 6'd1;
          if (rnd == 6'd63)
            state <= UPD;
        end
        UPD: begin
          v   <= v ^ {ra, rb, rc, rd, re, rf, rg, rh};
          ptr <= '0;
          if (pad_pend) begin
            pad_pend <= 1'b0;
            pad_pos  <= '0;
            state    <= PAD;
          end else if (len_pend) begin
            state <= PAD;
          end else if (!msg_done) begin
            in_ready <= 1'b1;
            state    <= LOAD;
          end else begin
            out_valid <= 1'b1;
            digest    <= v ^ {ra, rb, rc, rd, re, rf, rg, rh};
            state     <= OUT;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            v         <= IV;
            bit_cnt   <= '0;
            msg_done  <= 1'b0;
            in_ready  <= 1'b1;
            state     <= LOAD;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

  // Working registers track V while idle so a block starts from the current chain.
  always_ff @(posedge clk) begin
    case (state)
      LOAD: begin
        if (accept)
          blk[ptr] <= in_data;
        {ra, rb, rc, rd, re, rf, rg, rh} <= v;
      end
      PAD: begin
        for (int i = 0; i < 16; i++)
          blk[i] <= pad_blk[i];
        {ra, rb, rc, rd, re, rf, rg, rh} <= v;
      end
      COMP: begin
        for (int i = 0; i < 15; i++)
          blk[i] <= blk[i+1];
        blk[15] <= w_new;
        rd <= rc;
        rc <= rol(rb, 5'd9);
        rb <= ra;
        ra <= tt1;
        rh <= rg;
        rg <= rol(rf, 5'd19);
        rf <= re;
        re <= p0(tt2);
      end
      default: ;
    endcase
  end

endmodule
